disp_sched: RTL and testbench

Display scheduler that sits in front of the 7-segment BCD encoder inside the hardware timer. It shares the single encoder among NUM_SRC binary value sources, such as cycle, instruction and cache-miss counters. It rotates the displayed source on a dwell timer or on a manual advance. The encoder has no done/ack and blanks all digits once it returns to idle, so this block re-issues requests continuously to keep the display lit.

---
 rtl/disp_sched.sv | 163 ++++++++++++++++
 tb/tb_disp_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// Display scheduler: time-shares one 7-segment BCD encoder among NUM_SRC value
// sources, rotating on a dwell timer or manual advance, re-requesting to keep digits lit.
module disp_sched #(
  parameter int NUM_SRC      = 4,
  parameter int VAL_WIDTH    = 14,
  parameter int REQ_HOLD     = 64,
  parameter int ENC_BUSY     = 4800,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SRC*VAL_WIDTH-1:0]   src_val_i,
  input  logic [NUM_SRC-1:0]             src_en_i,
  input  logic                           hold_i,
  input  logic                           next_i,
  output logic [VAL_WIDTH-1:0]           enc_val_o,
  output logic                           enc_req_o,
  output logic [$clog2(NUM_SRC)-1:0]     cur_src_o,
  output logic                           active_o
);

  // state   | meaning
  // S_IDLE  | nothing enabled; encoder left idle so digits blank
  // S_LATCH | one cycle: pick the source and capture its value
  // S_REQ   | enc_req_o high for REQ_HOLD cycles
  // S_BUSY  | wait ENC_BUSY cycles for conversion and digit write-out
  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_REQ, S_BUSY} state_t;

  localparam int SW = $clog2(NUM_SRC);
  localparam int RW = (REQ_HOLD > 1) ? $clog2(REQ_HOLD) : 1;
  localparam int BW = (ENC_BUSY > 1) ? $clog2(ENC_BUSY) : 1;
  localparam int PW = (RW > BW) ? RW : BW;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [PW-1:0] REQ_LD   = PW'(REQ_HOLD - 1);
  localparam logic [PW-1:0] BUSY_LD  = PW'(ENC_BUSY - 1);
  localparam logic [DW-1:0] DWELL_TC = DW'(DWELL_CYCLES - 1);

  state_t               state_q;
  logic [PW-1:0]        phase_q;
  logic [DW-1:0]        dwell_q;
  logic                 adv_pend_q;
  logic [SW-1:0]        cur_src_q;
  logic [VAL_WIDTH-1:0] enc_val_q;
  logic                 enc_req_q;
  logic                 active_q;

  logic                 hi_found, lo_found;
  logic [SW-1:0]        hi_idx, lo_idx;
  logic [SW-1:0]        nxt_src_d;
  logic [VAL_WIDTH-1:0] sel_val_d;
  logic                 dwell_tick, dwell_exp, src_chg;

  // Round-robin: lowest enabled index above cur_src, else lowest enabled below it.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    nxt_src_d = cur_src_q;
    sel_val_d = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (src_en_i[j] && (SW'(j) > cur_src_q)) begin
        hi_found = 1'b1;
        hi_idx   = SW'(j);
      end
      if (src_en_i[j] && (SW'(j) < cur_src_q)) begin
        lo_found = 1'b1;
        lo_idx   = SW'(j);
      end
    end
    if (adv_pend_q || !src_en_i[cur_src_q]) begin
      if (hi_found) begin
        nxt_src_d = hi_idx;
      end else if (lo_found) begin
        nxt_src_d = lo_idx;
      end
    end
    for (int j = 0; j < NUM_SRC; j++) begin
      if (SW'(j) == nxt_src_d) begin
        sel_val_d = src_val_i[j*VAL_WIDTH +: VAL_WIDTH];
      end
    end
  end

  assign dwell_tick = active_q && !hold_i;
  assign dwell_exp  = dwell_tick && (dwell_q == DWELL_TC);
  assign src_chg    = (state_q == S_LATCH) && (nxt_src_d != cur_src_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      dwell_q    <= '0;
      adv_pend_q <= 1'b0;
      cur_src_q  <= '0;
      enc_val_q  <= '0;
      enc_req_q  <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (src_en_i != '0) begin
            state_q  <= S_LATCH;
            active_q <= 1'b1;
          end
        end
        S_LATCH: begin
          cur_src_q <= nxt_src_d;
          if (src_en_i == '0) begin
            state_q  <= S_IDLE;
            active_q <= 1'b0;
          end else begin
            enc_val_q <= sel_val_d;
            state_q   <= S_REQ;
            enc_req_q <= 1'b1;
            phase_q   <= REQ_LD;
          end
        end
        S_REQ: begin
          if (phase_q == '0) begin
            state_q   <= S_BUSY;
            enc_req_q <= 1'b0;
            phase_q   <= BUSY_LD;
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end
        S_BUSY: begin
          if (phase_q == '0) begin
            state_q <= S_LATCH;
          end else begin
            phase_q <= phase_q - 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          enc_req_q <= 1'b0;
          active_q  <= 1'b0;
        end
      endcase

      if (src_chg) begin
        dwell_q <= '0;
      end else if (dwell_tick) begin
        dwell_q <= (dwell_q == DWELL_TC) ? '0 : dwell_q + 1'b1;
      end

      // The latch cycle consumes any pending advance; events landing in it start a new one.
      if (state_q == S_LATCH) begin
        adv_pend_q <= next_i || (dwell_exp && !src_chg);
      end else if ((state_q != S_IDLE) && (next_i || dwell_exp)) begin
        adv_pend_q <= 1'b1;
      end
    end
  end

  assign enc_val_o = enc_val_q;
  assign enc_req_o = enc_req_q;
  assign cur_src_o = cur_src_q;
  assign active_o  = active_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed bench for disp_sched with REQ_HOLD=2, ENC_BUSY=5, DWELL_CYCLES=20
// (refresh period 8); expected cycle positions are hand-derived.
module tb_disp_sched;

  localparam int NS = 4;
  localparam int VW = 14;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS*VW-1:0] src_val;
  logic [NS-1:0]   src_en;
  logic            hold, nxt;
  logic [VW-1:0]   enc_val;
  logic            enc_req;
  logic [1:0]      cur_src;
  logic            active;
  logic [VW-1:0]   v0, v1, v2, v3;

  assign src_val = {v3, v2, v1, v0};

  disp_sched #(
    .NUM_SRC(NS), .VAL_WIDTH(VW), .REQ_HOLD(2), .ENC_BUSY(5), .DWELL_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_val_i(src_val), .src_en_i(src_en),
    .hold_i(hold), .next_i(nxt), .enc_val_o(enc_val), .enc_req_o(enc_req),
    .cur_src_o(cur_src), .active_o(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    en;
    logic [VW-1:0] val0;
    logic          req;
    logic          act;
    logic [VW-1:0] val;
  } vec_t;

  vec_t tbl[17];
  int   checks = 0;
  int   errors = 0;
  logic last_req = 1'b0;

  task automatic tick();
    last_req = enc_req;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_rise(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(enc_req && !last_req) && n < max);
    if (!(enc_req && !last_req)) begin
      checks++;
      errors++;
      $display("FAIL req_rise_timeout: no rising enc_req within %0d cycles", max);
    end
  endtask

  task automatic rise_chk(input string name, input int exp_n, input int exp_src, input int exp_val);
    int n;
    wait_rise(40, n);
    chk({name, "_gap"}, 32'(n), 32'(exp_n));
    chk({name, "_src"}, 32'(cur_src), 32'(exp_src));
    chk({name, "_val"}, 32'(enc_val), 32'(exp_val));
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    src_en = '0;
    hold   = 1'b0;
    nxt    = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    last_req = 1'b0;
  endtask

  initial begin
    int cnt;
    logic moved;

    for (int i = 0; i < 5; i++) tbl[i] = '{4'b0000, 14'd1234, 1'b0, 1'b0, 14'd0};
    tbl[5] = '{4'b0001, 14'd1234, 1'b0, 1'b1, 14'd0};
    tbl[6] = '{4'b0001, 14'd1234, 1'b1, 1'b1, 14'd1234};
    tbl[7] = '{4'b0001, 14'd1234, 1'b1, 1'b1, 14'd1234};
    for (int i = 8; i < 14; i++) tbl[i] = '{4'b0001, 14'd999, 1'b0, 1'b1, 14'd1234};
    tbl[14] = '{4'b0001, 14'd999, 1'b1, 1'b1, 14'd999};
    tbl[15] = '{4'b0001, 14'd999, 1'b1, 1'b1, 14'd999};
    tbl[16] = '{4'b0001, 14'd999, 1'b0, 1'b1, 14'd999};

    rst_n = 1'b0; src_en = '0; hold = 1'b0; nxt = 1'b0;
    v0 = 14'd1234; v1 = 14'd22; v2 = 14'd33; v3 = 14'd44;
    #1;
    chk("rst_req", 32'(enc_req), 32'd0);
    chk("rst_act", 32'(active), 32'd0);
    chk("rst_src", 32'(cur_src), 32'd0);
    chk("rst_val", 32'(enc_val), 32'd0);

    // Idle with nothing enabled, then a single source refreshing every 8 cycles.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      src_en = tbl[i].en;
      v0     = tbl[i].val0;
      tick();
      chk($sformatf("vec%0d_req", i), 32'(enc_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_act", i), 32'(active), 32'(tbl[i].act));
      chk($sformatf("vec%0d_val", i), 32'(enc_val), 32'(tbl[i].val));
      chk($sformatf("vec%0d_src", i), 32'(cur_src), 32'd0);
    end

    // Dwell rotation over all four sources: three refreshes per source.
    do_reset();
    v0 = 14'd11; src_en = 4'b1111;
    rise_chk("rot0", 2, 0, 11);
    rise_chk("rot1", 8, 0, 11);
    rise_chk("rot2", 8, 0, 11);
    rise_chk("rot3", 8, 1, 22);
    rise_chk("rot4", 8, 1, 22);
    rise_chk("rot5", 8, 1, 22);
    rise_chk("rot6", 8, 2, 33);
    rise_chk("rot7", 8, 2, 33);
    rise_chk("rot8", 8, 2, 33);
    rise_chk("rot9", 8, 3, 44);
    rise_chk("rot10", 8, 3, 44);
    rise_chk("rot11", 8, 3, 44);
    rise_chk("rot12", 8, 0, 11);

    // Manual advance with sparse enables, then next_i coinciding with dwell expiry.
    do_reset();
    src_en = 4'b1010;
    rise_chk("nx0", 2, 1, 22);
    tick(); tick();
    nxt = 1'b1; tick(); nxt = 1'b0;
    rise_chk("nx1", 5, 3, 44);
    tick(); tick();
    nxt = 1'b1; tick(); nxt = 1'b0;
    rise_chk("nx2", 5, 1, 22);
    repeat (19) tick();
    nxt = 1'b1; tick(); nxt = 1'b0;
    rise_chk("nx3", 4, 3, 44);
    rise_chk("nx4", 8, 3, 44);
    rise_chk("nx5", 8, 3, 44);
    rise_chk("nx6", 8, 1, 22);

    // Hold freezes dwell but not refreshes; dwell resumes from its held count.
    do_reset();
    src_en = 4'b1111;
    rise_chk("hd0", 2, 0, 11);
    tick(); tick(); tick();
    hold = 1'b1;
    cnt = 0; moved = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (enc_req && !last_req) cnt++;
      if (cur_src != 2'd0) moved = 1'b1;
    end
    chk("hold_refreshes", 32'(cnt), 32'd12);
    chk("hold_src_moved", 32'(moved), 32'd0);
    hold = 1'b0;
    rise_chk("hd1", 1, 0, 11);
    rise_chk("hd2", 8, 0, 11);
    rise_chk("hd3", 8, 1, 22);
    hold = 1'b1;
    tick(); tick();
    nxt = 1'b1; tick(); nxt = 1'b0;
    rise_chk("hd4", 5, 2, 33);
    rise_chk("hd5", 8, 2, 33);
    hold = 1'b0;

    // Disabling the current source mid-request lets the request finish.
    do_reset();
    src_en = 4'b0100;
    rise_chk("dis0", 2, 2, 33);
    src_en = 4'b0001;
    tick();
    chk("dis_req_2nd", 32'(enc_req), 32'd1);
    tick();
    chk("dis_req_end", 32'(enc_req), 32'd0);
    rise_chk("dis1", 6, 0, 11);

    // All sources off during busy: latch then idle, value and index retained.
    do_reset();
    src_en = 4'b0100;
    rise_chk("off0", 2, 2, 33);
    tick(); tick();
    src_en = 4'b0000;
    v2 = 14'd555;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("off_act%0d", i), 32'(active), 32'd1);
    end
    tick();
    chk("off_idle_act", 32'(active), 32'd0);
    chk("off_idle_req", 32'(enc_req), 32'd0);
    chk("off_idle_val", 32'(enc_val), 32'd33);
    chk("off_idle_src", 32'(cur_src), 32'd2);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enc_req || active) cnt++;
    end
    chk("off_stays_idle", 32'(cnt), 32'd0);
    src_en = 4'b0100;
    rise_chk("off1", 2, 2, 555);

    // Asynchronous reset while the request is high.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", 32'(enc_req), 32'd0);
    chk("arst_act", 32'(active), 32'd0);
    chk("arst_src", 32'(cur_src), 32'd0);
    chk("arst_val", 32'(enc_val), 32'd0);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
